// File: rtl/sprite_fetch_arbiter_if.sv
// sprite_fetch_arbiter_if: requester slots, per-slot line buffers and the shared
// sprite-ROM port of the sprite fetch arbiter, bundled as one interface.
// slave  : the arbiter side (consumes requests and ROM data).
// master : the environment side (requesters plus the ROM itself).
interface sprite_fetch_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_sprite_id;
  logic [2*NUM_REQ-1:0] req_orientation;
  logic [3*NUM_REQ-1:0] req_line;
  logic [NUM_REQ-1:0]   ack;
  logic [8*NUM_REQ-1:0] line_data;
  logic [NUM_REQ-1:0]   line_valid;
  logic                 busy;
  logic                 rom_read_enable;
  logic [1:0]           rom_orientation;
  logic [3:0]           rom_sprite_ID;
  logic [2:0]           rom_line_index;
  logic [7:0]           rom_data;

  modport slave (
    input  req, req_sprite_id, req_orientation, req_line, rom_data,
    output ack, line_data, line_valid, busy,
    output rom_read_enable, rom_orientation, rom_sprite_ID, rom_line_index
  );

  modport master (
    output req, req_sprite_id, req_orientation, req_line, rom_data,
    input  ack, line_data, line_valid, busy,
    input  rom_read_enable, rom_orientation, rom_sprite_ID, rom_line_index
  );

endinterface

// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: lets NUM_REQ requester slots share one combinational
// sprite ROM. A grant takes two cycles (IDLE registers the ROM address, READ
// captures the ROM line into the slot buffer) and is followed by a one-cycle ack.
// A slot whose ack is high is masked from arbitration so a request that is being
// dropped is never granted twice.
// Build option: define SPRITE_ARB_PRIORITY_EN to give slot 0 (player) strict
// priority, with round-robin among the remaining slots. Default is pure round-robin.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sprite_fetch_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ-1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [8*NUM_REQ-1:0] line_data_q, line_data_d;
  logic [NUM_REQ-1:0]   line_valid_q, line_valid_d;
  logic                 busy_q, busy_d;
  logic                 rom_read_enable_q, rom_read_enable_d;
  logic [3:0]           rom_sprite_id_q, rom_sprite_id_d;
  logic [1:0]           rom_orientation_q, rom_orientation_d;
  logic [2:0]           rom_line_index_q, rom_line_index_d;

  logic [NUM_REQ-1:0]   eligible_s;
  logic                 grant_s;
  logic [IDX_W-1:0]     pick_s;
  logic                 update_last_s;
  logic [NUM_REQ-1:0]   pick_oh_s;
  logic [NUM_REQ-1:0]   winner_oh_s;
  logic [3:0]           sel_sprite_id_s;
  logic [1:0]           sel_orientation_s;
  logic [2:0]           sel_line_s;

  // Round-robin search starting just after 'last'; returns {found, index}.
  // Candidates are visited farthest-first so the nearest eligible slot wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    res = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last) + off;
      cand = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
      cand_idx = IDX_W'(cand);
      res = elig[cand_idx] ? {1'b1, cand_idx} : res;
    end
    return res;
  endfunction

  // Choose a winner among requesting slots that are not being acked this cycle.
  always_comb begin
    eligible_s = bus.req & ~ack_q;
`ifdef SPRITE_ARB_PRIORITY_EN
    if (eligible_s[0]) begin
      grant_s       = 1'b1;
      pick_s        = '0;
      update_last_s = 1'b0;
    end else begin
      {grant_s, pick_s} = rr_pick(eligible_s, last_grant_q);
      update_last_s     = grant_s;
    end
`else
    {grant_s, pick_s} = rr_pick(eligible_s, last_grant_q);
    update_last_s     = grant_s;
`endif
  end

  // Route the picked slot's request fields toward the ROM address registers.
  always_comb begin
    pick_oh_s         = ONE_LSB << pick_s;
    winner_oh_s       = ONE_LSB << winner_q;
    sel_sprite_id_s   = 4'h0;
    sel_orientation_s = 2'd0;
    sel_line_s        = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_sprite_id_s   = sel_sprite_id_s   | (bus.req_sprite_id[4*i +: 4]   & {4{pick_oh_s[i]}});
      sel_orientation_s = sel_orientation_s | (bus.req_orientation[2*i +: 2] & {2{pick_oh_s[i]}});
      sel_line_s        = sel_line_s        | (bus.req_line[3*i +: 3]        & {3{pick_oh_s[i]}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> READ on a grant, READ always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: issue the ROM address at grant, capture and ack in READ.
  always_comb begin
    winner_d          = winner_q;
    last_grant_d      = last_grant_q;
    ack_d             = '0;
    line_data_d       = line_data_q;
    line_valid_d      = line_valid_q;
    rom_read_enable_d = 1'b0;
    rom_sprite_id_d   = rom_sprite_id_q;
    rom_orientation_d = rom_orientation_q;
    rom_line_index_d  = rom_line_index_q;
    busy_d            = (state_d == S_READ);
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          winner_d          = pick_s;
          last_grant_d      = update_last_s ? pick_s : last_grant_q;
          line_valid_d      = line_valid_q & ~pick_oh_s;
          rom_read_enable_d = 1'b1;
          rom_sprite_id_d   = sel_sprite_id_s;
          rom_orientation_d = sel_orientation_s;
          rom_line_index_d  = sel_line_s;
        end else begin
          rom_read_enable_d = 1'b0;
        end
      end
      S_READ: begin
        ack_d        = winner_oh_s;
        line_valid_d = line_valid_q | winner_oh_s;
        for (int i = 0; i < NUM_REQ; i++) begin
          line_data_d[8*i +: 8] = winner_oh_s[i] ? bus.rom_data : line_data_q[8*i +: 8];
        end
      end
      default: begin
        ack_d = '0;
      end
    endcase
  end

  // Datapath and output registers; reset blanks every line buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q      <= LAST_RST;
      winner_q          <= '0;
      ack_q             <= '0;
      line_data_q       <= {NUM_REQ{8'hFF}};
      line_valid_q      <= '0;
      busy_q            <= 1'b0;
      rom_read_enable_q <= 1'b0;
      rom_sprite_id_q   <= 4'hF;
      rom_orientation_q <= 2'd0;
      rom_line_index_q  <= 3'd0;
    end else begin
      last_grant_q      <= last_grant_d;
      winner_q          <= winner_d;
      ack_q             <= ack_d;
      line_data_q       <= line_data_d;
      line_valid_q      <= line_valid_d;
      busy_q            <= busy_d;
      rom_read_enable_q <= rom_read_enable_d;
      rom_sprite_id_q   <= rom_sprite_id_d;
      rom_orientation_q <= rom_orientation_d;
      rom_line_index_q  <= rom_line_index_d;
    end
  end

  assign bus.ack             = ack_q;
  assign bus.line_data       = line_data_q;
  assign bus.line_valid      = line_valid_q;
  assign bus.busy            = busy_q;
  assign bus.rom_read_enable = rom_read_enable_q;
  assign bus.rom_sprite_ID   = rom_sprite_id_q;
  assign bus.rom_orientation = rom_orientation_q;
  assign bus.rom_line_index  = rom_line_index_q;

endmodule
